// File: rtl/bt_calc_sequencer.sv
// Balanced-ternary accumulator sequencer: LOAD/ADD/MUL/NEG on a 4-trit
// accumulator, serialised through one single-trit full adder.

module bt_calc_sequencer_chk #(
    parameter int NTRIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 in_ready,
    input logic                 out_valid,
    input logic                 out_ready,
    input logic [2*NTRIT-1:0]   out_data,
    input logic                 out_ovf,
    input logic                 out_err
);
    logic w_null;

    // Flag any trit of the visible accumulator that carries the unused 00 code
    always_comb begin
        w_null = 1'b0;
        for (int i = 0; i < NTRIT; i++) begin
            if (out_data[2*i +: 2] == 2'b00) begin
                w_null = 1'b1;
            end else begin
                w_null = w_null;
            end
        end
    end

    a_no_null_trit: assert property (@(posedge clk) disable iff (rst) !w_null);
    a_ready_xor_valid: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
    a_resp_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ovf) && $stable(out_err)));
endmodule

module bt_calc_sequencer #(
    parameter int NTRIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_cmd,
    input  logic [2*NTRIT-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*NTRIT-1:0]   out_data,
    output logic                 out_ovf,
    output logic                 out_err
);
    localparam int W  = 2 * NTRIT;
    localparam int IW = (NTRIT > 1) ? $clog2(NTRIT) : 1;

    localparam logic [1:0]    CMD_LOAD = 2'b00;
    localparam logic [1:0]    CMD_ADD  = 2'b01;
    localparam logic [1:0]    CMD_MUL  = 2'b10;
    localparam logic [1:0]    CMD_NEG  = 2'b11;
    localparam logic [1:0]    T_ZERO   = 2'b11;
    localparam logic [W-1:0]  W_ZERO   = {NTRIT{2'b11}};
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NTRIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic [2:0] trit_dec(input logic [1:0] t);
        case (t)
            2'b10:   trit_dec = 3'b001;
            2'b01:   trit_dec = 3'b111;
            default: trit_dec = 3'b000;
        endcase
    endfunction

    // Returns {carry_trit, sum_trit}; the raw sum spans -3..+3
    function automatic logic [3:0] trit_fa(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        logic [2:0] s;
        s = trit_dec(a) + trit_dec(b) + trit_dec(c);
        case (s)
            3'b011:  trit_fa = {2'b10, 2'b11};
            3'b010:  trit_fa = {2'b10, 2'b01};
            3'b001:  trit_fa = {2'b11, 2'b10};
            3'b000:  trit_fa = {2'b11, 2'b11};
            3'b111:  trit_fa = {2'b11, 2'b01};
            3'b110:  trit_fa = {2'b01, 2'b10};
            3'b101:  trit_fa = {2'b01, 2'b11};
            default: trit_fa = {2'b11, 2'b11};
        endcase
    endfunction

    // Negating a trit is a swap of its two code bits (10 <-> 01, 11 stays)
    function automatic logic [W-1:0] word_neg(input logic [W-1:0] x);
        for (int i = 0; i < NTRIT; i++) begin
            word_neg[2*i +: 2] = {x[2*i], x[2*i+1]};
        end
    endfunction

    function automatic logic word_bad(input logic [W-1:0] x);
        word_bad = 1'b0;
        for (int i = 0; i < NTRIT; i++) begin
            if (x[2*i +: 2] == 2'b00) begin
                word_bad = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] trit_at(input logic [W-1:0] x, input logic [IW-1:0] idx);
        trit_at = x[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [W-1:0] word_set(input logic [W-1:0] x, input logic [IW-1:0] idx,
                                              input logic [1:0] t);
        word_set = x;
        word_set[{idx, 1'b0} +: 2] = t;
    endfunction

    function automatic logic [W-1:0] word_shl(input logic [W-1:0] x);
        word_shl = {x[W-3:0], T_ZERO};
    endfunction

    function automatic logic [W-1:0] word_sel(input logic [1:0] d, input logic [W-1:0] a);
        case (d)
            2'b10:   word_sel = a;
            2'b01:   word_sel = word_neg(a);
            default: word_sel = W_ZERO;
        endcase
    endfunction

    state_t        r_state;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_opnd;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_sum;
    logic [1:0]    r_carry;
    logic [IW-1:0] r_tidx;
    logic [IW-1:0] r_step;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_ovf;
    logic          r_err;

    logic [3:0]    w_fa;
    logic [W-1:0]  w_sum;
    logic [IW-1:0] w_step_dn;

    assign w_fa      = trit_fa(trit_at(r_opa, r_tidx), trit_at(r_opb, r_tidx), r_carry);
    assign w_sum     = word_set(r_sum, r_tidx, w_fa[1:0]);
    assign w_step_dn = r_step - IDX_ONE;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;
    assign out_err   = r_err;

    // Command FSM: accept in IDLE, ripple one trit per cycle in ADD/MUL, hold in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= W_ZERO;
            r_opnd      <= W_ZERO;
            r_opa       <= W_ZERO;
            r_opb       <= W_ZERO;
            r_sum       <= W_ZERO;
            r_carry     <= T_ZERO;
            r_tidx      <= IDX_ZERO;
            r_step      <= IDX_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opnd     <= in_data;
                        r_in_ready <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_err      <= 1'b0;
                        r_tidx     <= IDX_ZERO;
                        r_carry    <= T_ZERO;
                        r_sum      <= W_ZERO;
                        if ((in_cmd != CMD_NEG) && word_bad(in_data)) begin
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            case (in_cmd)
                                CMD_LOAD: begin
                                    r_acc       <= in_data;
                                    r_out_valid <= 1'b1;
                                    r_state     <= S_RESP;
                                end
                                CMD_NEG: begin
                                    r_acc       <= word_neg(r_acc);
                                    r_out_valid <= 1'b1;
                                    r_state     <= S_RESP;
                                end
                                CMD_ADD: begin
                                    r_opa   <= r_acc;
                                    r_opb   <= in_data;
                                    r_state <= S_ADD;
                                end
                                CMD_MUL: begin
                                    // Horner starts from p = 0, so the first shifted partial is zero
                                    r_opa   <= W_ZERO;
                                    r_opb   <= word_sel(in_data[W-1 -: 2], r_acc);
                                    r_step  <= IDX_LAST;
                                    r_state <= S_MUL;
                                end
                                default: begin
                                    r_out_valid <= 1'b1;
                                    r_state     <= S_RESP;
                                end
                            endcase
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_carry <= w_fa[3:2];
                    if (r_tidx == IDX_LAST) begin
                        r_tidx      <= IDX_ZERO;
                        r_acc       <= w_sum;
                        r_ovf       <= (w_fa[3:2] != T_ZERO);
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tidx <= r_tidx + IDX_ONE;
                    end
                end
                S_MUL: begin
                    r_sum   <= w_sum;
                    r_carry <= w_fa[3:2];
                    if (r_tidx == IDX_LAST) begin
                        r_tidx <= IDX_ZERO;
                        if (r_step == IDX_ZERO) begin
                            r_acc       <= w_sum;
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            // Carry out of the top trit is dropped: arithmetic is modulo 81
                            r_opa   <= word_shl(w_sum);
                            r_opb   <= word_sel(trit_at(r_opnd, w_step_dn), r_acc);
                            r_step  <= w_step_dn;
                            r_carry <= T_ZERO;
                            r_sum   <= W_ZERO;
                        end
                    end else begin
                        r_tidx <= r_tidx + IDX_ONE;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    bt_calc_sequencer_chk #(.NTRIT(NTRIT)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );
endmodule

// File: tb/tb_bt_calc_sequencer.sv
// Scoreboard bench for bt_calc_sequencer: an integer balanced-ternary model
// pushes expected responses, which are popped when the DUT raises out_valid.

module tb_bt_calc_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_cmd;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       out_err;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_acc = 0;

    bt_calc_sequencer #(.NTRIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int trit_val(input logic [1:0] t);
        if (t == 2'b10) return 1;
        if (t == 2'b01) return -1;
        return 0;
    endfunction

    function automatic int to_int(input logic [7:0] d);
        return trit_val(d[1:0]) + 3 * trit_val(d[3:2]) + 9 * trit_val(d[5:4]) + 27 * trit_val(d[7:6]);
    endfunction

    function automatic bit has_bad(input logic [7:0] d);
        return (d[1:0] == 2'b00) || (d[3:2] == 2'b00) || (d[5:4] == 2'b00) || (d[7:6] == 2'b00);
    endfunction

    function automatic int wrap81(input int v);
        int r;
        r = v % 81;
        if (r > 40) r -= 81;
        if (r < -40) r += 81;
        return r;
    endfunction

    function automatic logic [7:0] enc(input int v);
        logic [7:0] w;
        int r;
        w = 8'h00;
        for (int i = 0; i < 4; i++) begin
            r = v % 3;
            if (r < 0) r += 3;
            if (r == 0) begin
                w[2*i +: 2] = 2'b11;
                v = v / 3;
            end else if (r == 1) begin
                w[2*i +: 2] = 2'b10;
                v = (v - 1) / 3;
            end else begin
                w[2*i +: 2] = 2'b01;
                v = (v + 1) / 3;
            end
        end
        return w;
    endfunction

    task automatic push_expect(input logic [1:0] cmd, input logic [7:0] data);
        exp_t e;
        int   s;
        e.ovf = 1'b0;
        e.err = 1'b0;
        e.lat = 1;
        if (cmd != 2'b11 && has_bad(data)) begin
            e.err = 1'b1;
        end else begin
            case (cmd)
                2'b00: m_acc = to_int(data);
                2'b01: begin
                    s     = m_acc + to_int(data);
                    e.ovf = (s > 40) || (s < -40);
                    m_acc = wrap81(s);
                    e.lat = 5;
                end
                2'b10: begin
                    m_acc = wrap81(m_acc * to_int(data));
                    e.lat = 17;
                end
                default: m_acc = -m_acc;
            endcase
        end
        e.data = enc(m_acc);
        sb_q.push_back(e);
    endtask

    task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] data, input int hold);
        exp_t e;
        int   lat;
        bit   ready_hi;
        bit   stable;
        push_expect(cmd, data);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cmd   = ~cmd;
        in_data  = 8'h00;
        lat      = 1;
        ready_hi = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_hi = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        check_val("resp_seen", out_valid, 1'b1);
        check_val("latency", lat, e.lat);
        check_val("busy_ready", ready_hi, 1'b0);
        check_val("data", out_data, e.data);
        check_val("ovf", out_ovf, e.ovf);
        check_val("err", out_err, e.err);
        check_val("resp_ready", in_ready, 1'b0);
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out_data !== e.data || out_ovf !== e.ovf || out_err !== e.err)
                stable = 1'b0;
        end
        check_val("hold_stable", stable, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("idle_ready", in_ready, 1'b1);
        check_val("idle_valid", out_valid, 1'b0);
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       w[2*i +: 2] = 2'b10;
                1:       w[2*i +: 2] = 2'b01;
                default: w[2*i +: 2] = 2'b11;
            endcase
        end
        if ($urandom_range(0, 7) == 0) w[1:0] = 2'b00;
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_cmd    = 2'b00;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", out_valid, 1'b0);
        check_val("rst_data", out_data, 8'hFF);
        check_val("rst_ready", in_ready, 1'b1);
        check_val("rst_ovf", out_ovf, 1'b0);
        check_val("rst_err", out_err, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        m_acc = 0;

        run_cmd(2'b00, 8'hE5, 0);
        run_cmd(2'b01, 8'hE5, 0);
        check_val("add_e5_e5", out_data, 8'hEE);

        run_cmd(2'b00, 8'hAA, 0);
        run_cmd(2'b01, 8'hFE, 0);
        check_val("add_wrap", out_data, 8'h55);

        run_cmd(2'b00, 8'hE5, 0);
        run_cmd(2'b10, 8'hF6, 0);
        check_val("mul_5_m2", out_data, 8'hDD);

        run_cmd(2'b00, 8'hE5, 0);
        run_cmd(2'b11, 8'h00, 0);
        check_val("neg_5", out_data, 8'hDA);
        run_cmd(2'b01, 8'h00, 0);
        check_val("err_keep", out_data, 8'hDA);

        run_cmd(2'b00, 8'hEE, 10);
        run_cmd(2'b01, 8'h55, 3);

        for (int n = 0; n < 20; n++) begin
            run_cmd(2'($urandom_range(0, 3)), rand_word(), $urandom_range(0, 2));
        end

        run_cmd(2'b00, 8'hE5, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = 2'b10;
        in_data  = 8'hF6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_val("mul_busy", out_valid, 1'b0);
        rst = 1'b1;
        #1;
        check_val("abort_valid", out_valid, 1'b0);
        check_val("abort_data", out_data, 8'hFF);
        check_val("abort_ready", in_ready, 1'b1);
        @(negedge clk);
        rst   = 1'b0;
        m_acc = 0;
        run_cmd(2'b00, 8'hFE, 0);
        check_val("load_after_rst", out_data, 8'hFE);

        check_val("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
